// File: rtl/em_write_ctrl_pkg.sv
// Shared definitions for the stochastic-decoder resampling blocks: LFSR geometry,
// the default seed and the edge-memory controller state encoding.
package em_write_ctrl_pkg;

   localparam int          LFSR_W       = 16;
   // Fibonacci taps 16,14,13,11 seen from a right-shifting register: bits 0,2,3,5
   localparam logic [15:0] LFSR_TAPS    = 16'h002D;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } em_state_t;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
      return {^(q & LFSR_TAPS), q[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/em_write_ctrl_lfsr.sv
// 16-bit Fibonacci LFSR shared by the resampling blocks; advances once per enabled cycle.
module sc_lfsr16
   import em_write_ctrl_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              EN,
   input  logic [LFSR_W-1:0] SEED,
   output logic [LFSR_W-1:0] Q
);

   logic [LFSR_W-1:0] seed_safe;

   // An all-zero state would lock the register forever
   assign seed_safe = (SEED == '0) ? 16'h0001 : SEED;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         Q <= seed_safe;
      end else if (EN) begin
         Q <= lfsr_step(Q);
      end
   end

endmodule

// File: rtl/em_write_ctrl.sv
// Producer-side controller for one edge memory: shifts regenerative bits into the EM
// and, on hold cycles, replays a pseudo-randomly addressed EM bit.
module em_write_ctrl
   import em_write_ctrl_pkg::*;
#(
   parameter int          N    = 8,
   parameter int          NS   = 3,
   parameter int          NI   = 3,
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          EN,
   input  logic [NI-1:0] IN,
   input  logic          EM_Q,
   output logic          EM_WE,
   output logic          EM_D,
   output logic [NS-1:0] EM_SEL,
   output logic          OUT,
   output logic          HOLD,
   output logic          FULL
);

   localparam logic [NS:0] FILL_MAX = (NS+1)'(N);

   logic [LFSR_W-1:0] lfsr_q;
   logic [NS-1:0]     sel_next;
   logic [NS:0]       fill_cnt;
   logic [NS:0]       fill_inc;
   logic              regen;
   em_state_t         state;

   sc_lfsr16 u_lfsr (
      .CLK   (CLK),
      .RESET (RESET),
      .EN    (EN),
      .SEED  (SEED),
      .Q     (lfsr_q)
   );

   // EM_SEL tracks the value the LFSR takes on this same edge
   assign sel_next = NS'(lfsr_step(lfsr_q));
   assign regen    = (&IN) | (~|IN);
   assign fill_inc = (fill_cnt == FILL_MAX) ? fill_cnt : fill_cnt + 1'b1;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= FILL;
         fill_cnt <= '0;
         EM_WE    <= 1'b0;
         EM_D     <= 1'b0;
         EM_SEL   <= '0;
         OUT      <= 1'b0;
         HOLD     <= 1'b0;
         FULL     <= 1'b0;
      end else if (EN) begin
         EM_SEL <= sel_next;
         if (regen) begin
            OUT      <= IN[0];
            EM_D     <= IN[0];
            EM_WE    <= 1'b1;
            HOLD     <= 1'b0;
            fill_cnt <= fill_inc;
            if (fill_inc == FILL_MAX) begin
               FULL  <= 1'b1;
               state <= RUN;
            end
         end else begin
            // Until the EM is full its contents may be stale, so fall back to the channel bit
            OUT   <= (state == RUN) ? EM_Q : IN[0];
            EM_WE <= 1'b0;
            HOLD  <= 1'b1;
         end
      end else begin
         EM_WE <= 1'b0;
      end
   end

endmodule

// File: tb/tb_em_write_ctrl.sv
// Bench for em_write_ctrl: directed phases plus a randomized run, all checked against
// a transaction-level model of the controller and of the paired shift-register EM.
module tb_em_write_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [2:0] in_b = 3'b000;
   logic       em_q;
   logic       em_we;
   logic       em_d;
   logic [2:0] em_sel;
   logic       out_b;
   logic       hold;
   logic       full;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [15:0] m_lfsr = 16'hACE1;
   logic [2:0]  m_sel  = 3'd0;
   logic        m_out  = 1'b0;
   logic        m_we   = 1'b0;
   logic        m_d    = 1'b0;
   logic        m_hold = 1'b0;
   logic        m_full = 1'b0;
   int          m_cnt  = 0;
   logic [7:0]  em_m   = 8'h00;

   always #5 clk = ~clk;

   // The paired EM presents the bit at the address the DUT drives
   assign em_q = em_m[em_sel];

   em_write_ctrl #(.N(8), .NS(3), .NI(3), .SEED(16'hACE1)) dut (
      .CLK    (clk),
      .RESET  (reset),
      .EN     (en),
      .IN     (in_b),
      .EM_Q   (em_q),
      .EM_WE  (em_we),
      .EM_D   (em_d),
      .EM_SEL (em_sel),
      .OUT    (out_b),
      .HOLD   (hold),
      .FULL   (full)
   );

   function automatic logic [15:0] model_lfsr(input logic [15:0] s);
      int   taps[4] = '{16, 14, 13, 11};
      logic fb = 1'b0;
      for (int k = 0; k < 4; k++) fb ^= s[16 - taps[k]];
      return {fb, s[15:1]};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [2:0] i, input string tag);
      logic [7:0] em_next;
      logic       rd;
      @(negedge clk);
      reset = r;
      en    = e;
      in_b  = i;
      rd      = em_m[m_sel];
      em_next = m_we ? {em_m[6:0], m_d} : em_m;
      if (r) begin
         m_lfsr = 16'hACE1;
         m_sel  = 3'd0;
         m_out  = 1'b0;
         m_we   = 1'b0;
         m_d    = 1'b0;
         m_hold = 1'b0;
         m_full = 1'b0;
         m_cnt  = 0;
      end else if (e) begin
         m_lfsr = model_lfsr(m_lfsr);
         m_sel  = m_lfsr[2:0];
         if (i == 3'b000 || i == 3'b111) begin
            m_out  = i[0];
            m_d    = i[0];
            m_we   = 1'b1;
            m_hold = 1'b0;
            if (m_cnt < 8) m_cnt++;
            m_full = (m_cnt == 8);
         end else begin
            m_out  = m_full ? rd : i[0];
            m_we   = 1'b0;
            m_hold = 1'b1;
         end
      end else begin
         m_we = 1'b0;
      end
      @(posedge clk);
      #1;
      em_m = em_next;
      chk({tag, ".out"},    16'(out_b),  16'(m_out));
      chk({tag, ".em_we"},  16'(em_we),  16'(m_we));
      chk({tag, ".em_sel"}, 16'(em_sel), 16'(m_sel));
      chk({tag, ".hold"},   16'(hold),   16'(m_hold));
      chk({tag, ".full"},   16'(full),   16'(m_full));
      if (m_we) chk({tag, ".em_d"}, 16'(em_d), 16'(m_d));
   endtask

   initial begin
      logic [7:0] pat;
      logic [2:0] rin;
      pat = 8'b10110010;

      // Reset held two cycles with EN high
      step(1'b1, 1'b1, 3'b101, "reset0");
      step(1'b1, 1'b1, 3'b101, "reset1");
      chk("reset.sel_zero", 16'(em_sel), 16'h0000);

      // Regenerative fill with all ones
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 3'b111, "fill_ones");
      chk("fill_ones.full", 16'(full), 16'h0001);
      step(1'b0, 1'b1, 3'b011, "fill_ones.hold_run");

      // Hold during fill falls back to the channel bit
      step(1'b1, 1'b1, 3'b000, "reset2");
      step(1'b0, 1'b1, 3'b110, "fill_hold");
      chk("fill_hold.out_chan", 16'(out_b), 16'h0000);
      step(1'b0, 1'b1, 3'b001, "fill_hold2");
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 3'b000, "fill_zero");

      // Patterned fill, then run-phase holds reading the EM
      step(1'b1, 1'b1, 3'b000, "reset3");
      for (int k = 7; k >= 0; k--) step(1'b0, 1'b1, {3{pat[k]}}, "fill_pat");
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 3'b011, "run_hold");

      // Enable gating mid-sequence
      for (int k = 0; k < 5; k++) begin
         rin = 3'($urandom_range(1, 6));
         step(1'b0, 1'b0, rin, "en_low");
      end
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 3'b011, "run_resume");

      // Reset mid-run discards fill history
      step(1'b1, 1'b1, 3'b011, "reset_mid");
      step(1'b0, 1'b1, 3'b001, "post_reset_hold");
      chk("post_reset.out_chan", 16'(out_b), 16'h0001);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         logic r, e;
         r = ($urandom_range(0, 59) == 0);
         e = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) rin = $urandom_range(0, 1) ? 3'b111 : 3'b000;
         else                           rin = 3'($urandom_range(0, 7));
         step(r, e, rin, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
